// File: rtl/noc_if_pkg.sv
// noc_if_pkg: shared definitions for the CONNECT send-port flit injector and
// for PE models and monitors attached to it.
//   - default configuration constants and the derived widths
//     (VC_BITS, FLIT_W, CREDIT_W)
//   - flit_t / credit_t packed structs matching the network wire layout
//   - pack_flit helper that builds a valid flit from its fields
package noc_if_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DEST_BITS   = 4;
    localparam int NUM_VCS     = 2;
    localparam int CREDIT_INIT = 8;
    localparam int FIFO_DEPTH  = 4;

    // A single VC still needs a one-bit VC field on the wire.
    function automatic int vc_bits_of(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    localparam int VC_BITS  = vc_bits_of(NUM_VCS);
    localparam int FLIT_W   = 2 + DEST_BITS + VC_BITS + DATA_WIDTH;
    localparam int CREDIT_W = 1 + VC_BITS;

    typedef struct packed {
        logic                  valid;
        logic                  tail;
        logic [DEST_BITS-1:0]  dest;
        logic [VC_BITS-1:0]    vc;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    typedef struct packed {
        logic               valid;
        logic [VC_BITS-1:0] vc;
    } credit_t;

    function automatic flit_t pack_flit(input logic                  tail,
                                        input logic [DEST_BITS-1:0]  dest,
                                        input logic [VC_BITS-1:0]    vc,
                                        input logic [DATA_WIDTH-1:0] data);
        flit_t f;
        f.valid = 1'b1;
        f.tail  = tail;
        f.dest  = dest;
        f.vc    = vc;
        f.data  = data;
        return f;
    endfunction

endpackage

// File: rtl/noc_flit_injector_fifo.sv
// flit_fifo: synchronous FIFO holding flits (without the valid bit) between
// the PE handshake and the network issue stage.
//   clk, rst        clock, asynchronous active-high reset (flushes contents)
//   push, push_data write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head_data       current head entry, valid while !empty
//   full, empty     registered status flags
//   count           number of stored entries
module flit_fifo
    import noc_if_pkg::*;
#(
    parameter int WIDTH = FLIT_W - 1,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic [AW:0]      count_next_s;

    assign do_push_s    = push && !full_r;
    assign do_pop_s     = pop && !empty_r;
    assign count_next_s = count_r + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};

    assign head_data = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;
    assign count     = count_r;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (AW+1)'(DEPTH));
            empty_r <= (count_next_s == {(AW+1){1'b0}});
        end
    end

endmodule

// File: rtl/noc_flit_injector.sv
// noc_flit_injector: credit-based flit injector from a PE into one CONNECT
// send port. Flits are buffered in a small FIFO and issued strictly in order,
// at most one per cycle, only while the head flit's VC holds a credit.
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/in_ready, in_tail, in_dest, in_vc, in_data   PE flit handshake
//   flit_out, send_flit      packed {valid,tail,dest,vc,data} + putFlit enable
//   credit_in, en_recv_credit  {valid,vc} credit return + getCredits enable
//   credits_avail   per-VC "counter nonzero" (registered)
//   err_credit_ovf  sticky: credit returned to a VC already at CREDIT_INIT
//   idle            FIFO empty and every counter at CREDIT_INIT (registered)
module noc_flit_injector
    import noc_if_pkg::*;
#(
    parameter int DATA_WIDTH  = noc_if_pkg::DATA_WIDTH,
    parameter int DEST_BITS   = noc_if_pkg::DEST_BITS,
    parameter int NUM_VCS     = noc_if_pkg::NUM_VCS,
    parameter int CREDIT_INIT = noc_if_pkg::CREDIT_INIT,
    parameter int FIFO_DEPTH  = noc_if_pkg::FIFO_DEPTH,
    localparam int VC_BITS    = vc_bits_of(NUM_VCS),
    localparam int FLIT_W     = 2 + DEST_BITS + VC_BITS + DATA_WIDTH,
    localparam int CREDIT_W   = 1 + VC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_tail,
    input  logic [DEST_BITS-1:0]  in_dest,
    input  logic [VC_BITS-1:0]    in_vc,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [FLIT_W-1:0]     flit_out,
    output logic                  send_flit,
    input  logic [CREDIT_W-1:0]   credit_in,
    output logic                  en_recv_credit,
    output logic [NUM_VCS-1:0]    credits_avail,
    output logic                  err_credit_ovf,
    output logic                  idle
);

    localparam int CNT_W = $clog2(CREDIT_INIT + 1);
    localparam int ENT_W = FLIT_W - 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_INIT);

    logic [ENT_W-1:0]   head_s;
    logic               full_s;
    logic               empty_s;
    logic [FCW-1:0]     fifo_count_s;
    logic               push_s;
    logic               pop_s;
    logic [VC_BITS-1:0] head_vc_s;
    logic               ret_valid_s;
    logic [VC_BITS-1:0] ret_vc_s;
    logic               ovf_s;
    logic               idle_next_s;
    logic [CNT_W-1:0]   credit_r      [NUM_VCS];
    logic [CNT_W-1:0]   credit_next_s [NUM_VCS];

    // Ready depends only on registered fullness, never on a same-cycle pop.
    assign in_ready       = !full_s && !rst;
    assign push_s         = in_valid && in_ready;
    assign en_recv_credit = !rst;
    assign head_vc_s      = head_s[DATA_WIDTH +: VC_BITS];
    assign ret_valid_s    = credit_in[CREDIT_W-1];
    assign ret_vc_s       = credit_in[VC_BITS-1:0];

    flit_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({in_tail, in_dest, in_vc, in_data}),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_count_s)
    );

    // Issue decision and next credit state, all from pre-edge counters so a
    // returning credit only becomes usable one cycle later.
    always_comb begin
        logic dec_v;
        logic inc_v;
        logic all_full_v;
        pop_s      = 1'b0;
        ovf_s      = 1'b0;
        all_full_v = 1'b1;
        dec_v      = 1'b0;
        inc_v      = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (!empty_s && (head_vc_s == VC_BITS'(v)) && (credit_r[v] != {CNT_W{1'b0}})) begin
                pop_s = 1'b1;
            end else begin
                pop_s = pop_s;
            end
        end
        for (int v = 0; v < NUM_VCS; v++) begin
            dec_v = pop_s && (head_vc_s == VC_BITS'(v));
            inc_v = ret_valid_s && (ret_vc_s == VC_BITS'(v));
            if (inc_v && !dec_v) begin
                if (credit_r[v] == CNT_MAX) begin
                    credit_next_s[v] = credit_r[v];
                    ovf_s            = 1'b1;
                end else begin
                    credit_next_s[v] = credit_r[v] + CNT_W'(1);
                end
            end else if (dec_v && !inc_v) begin
                credit_next_s[v] = credit_r[v] - CNT_W'(1);
            end else begin
                credit_next_s[v] = credit_r[v];
            end
            if (credit_next_s[v] != CNT_MAX) begin
                all_full_v = 1'b0;
            end else begin
                all_full_v = all_full_v;
            end
        end
        // FIFO is empty after the edge if nothing is pushed and it either
        // is empty now or holds one entry that is being popped.
        idle_next_s = all_full_v && !push_s &&
                      ((fifo_count_s == FCW'(0)) || ((fifo_count_s == FCW'(1)) && pop_s));
    end

    // Credit counters and all registered network-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_r[v] <= CNT_MAX;
            end
            flit_out       <= {FLIT_W{1'b0}};
            send_flit      <= 1'b0;
            credits_avail  <= {NUM_VCS{1'b1}};
            err_credit_ovf <= 1'b0;
            idle           <= 1'b1;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_r[v]      <= credit_next_s[v];
                credits_avail[v] <= (credit_next_s[v] != {CNT_W{1'b0}});
            end
            send_flit      <= pop_s;
            flit_out       <= pop_s ? {1'b1, head_s} : {FLIT_W{1'b0}};
            err_credit_ovf <= err_credit_ovf | ovf_s;
            idle           <= idle_next_s;
        end
    end

endmodule

// File: tb/tb_noc_flit_injector.sv
// Self-checking bench for noc_flit_injector: a queue-based reference model
// (FIFO of pending flits plus per-VC credit integers) is compared against
// every output on every cycle, with directed scenarios and a random phase.
module tb_noc_flit_injector;

    localparam int DW = 32;
    localparam int DB = 4;
    localparam int NV = 2;
    localparam int CI = 8;
    localparam int FD = 4;
    localparam int VB = 1;
    localparam int FW = 2 + DB + VB + DW;
    localparam int CW = 1 + VB;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_tail;
    logic [DB-1:0] in_dest;
    logic [VB-1:0] in_vc;
    logic [DW-1:0] in_data;
    logic [FW-1:0] flit_out;
    logic          send_flit;
    logic [CW-1:0] credit_in;
    logic          en_recv_credit;
    logic [NV-1:0] credits_avail;
    logic          err_credit_ovf;
    logic          idle;

    noc_flit_injector dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_tail        (in_tail),
        .in_dest        (in_dest),
        .in_vc          (in_vc),
        .in_data        (in_data),
        .flit_out       (flit_out),
        .send_flit      (send_flit),
        .credit_in      (credit_in),
        .en_recv_credit (en_recv_credit),
        .credits_avail  (credits_avail),
        .err_credit_ovf (err_credit_ovf),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_sends = 0;

    typedef struct {
        logic          tail;
        logic [DB-1:0] dest;
        logic [VB-1:0] vc;
        logic [DW-1:0] data;
    } mflit_t;

    mflit_t        mq[$];
    int            m_cred [NV];
    logic          m_send;
    logic [FW-1:0] m_flit;
    logic          m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_idle();
        logic r;
        r = (mq.size() == 0);
        for (int v = 0; v < NV; v++) if (m_cred[v] != CI) r = 1'b0;
        return r;
    endfunction

    function automatic logic [NV-1:0] model_avail();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (m_cred[v] > 0);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int v = 0; v < NV; v++) m_cred[v] = CI;
        m_send = 1'b0;
        m_flit = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic clear_in();
        in_valid  = 1'b0;
        in_tail   = 1'b0;
        in_dest   = '0;
        in_vc     = '0;
        in_data   = '0;
        credit_in = '0;
    endtask

    task automatic set_in(input logic t, input logic [DB-1:0] d, input logic [VB-1:0] v, input logic [DW-1:0] x);
        in_valid = 1'b1;
        in_tail  = t;
        in_dest  = d;
        in_vc    = v;
        in_data  = x;
    endtask

    task automatic set_cr(input logic [VB-1:0] v);
        credit_in = {1'b1, v};
    endtask

    task automatic compare_all();
        chk("send_flit", send_flit, m_send);
        chk("flit_out", flit_out, m_flit);
        chk("credits_avail", credits_avail, model_avail());
        chk("err_credit_ovf", err_credit_ovf, m_ovf);
        chk("idle", idle, model_idle());
        chk("in_ready", in_ready, mq.size() < FD);
        chk("en_recv_credit", en_recv_credit, 1'b1);
    endtask

    // One clock: advance the model with the driven inputs, clock the DUT,
    // compare at the following negedge, then release the inputs.
    task automatic tick();
        logic   acc;
        logic   issue;
        int     ivc;
        int     cv;
        mflit_t h;
        acc   = in_valid && (mq.size() < FD);
        issue = 1'b0;
        ivc   = -1;
        if (mq.size() > 0 && m_cred[mq[0].vc] > 0) begin
            issue  = 1'b1;
            h      = mq.pop_front();
            ivc    = int'(h.vc);
            m_flit = {1'b1, h.tail, h.dest, h.vc, h.data};
        end else begin
            m_flit = '0;
        end
        m_send = issue;
        if (credit_in[CW-1]) begin
            cv = int'(credit_in[VB-1:0]);
            if (m_cred[cv] == CI && !(issue && ivc == cv)) m_ovf = 1'b1;
            else m_cred[cv]++;
        end
        if (issue) m_cred[ivc]--;
        if (acc) mq.push_back('{in_tail, in_dest, in_vc, in_data});
        @(posedge clk);
        @(negedge clk);
        if (send_flit === 1'b1) dut_sends++;
        compare_all();
        clear_in();
    endtask

    // Return outstanding credits until the model is idle again.
    task automatic drain();
        for (int i = 0; i < 300 && !model_idle(); i++) begin
            for (int v = 0; v < NV; v++) begin
                if (m_cred[v] < CI && credit_in[CW-1] == 1'b0) set_cr(VB'(v));
            end
            tick();
        end
        chk("drain_model_idle", model_idle(), 1'b1);
        chk("drain_idle", idle, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int acc2;
        int guard;
        clear_in();
        model_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_send", send_flit, 1'b0);
        chk("rst_flit", flit_out, 39'h0);
        chk("rst_en_credit", en_recv_credit, 1'b0);
        chk("rst_avail", credits_avail, 2'b11);
        chk("rst_ovf", err_credit_ovf, 1'b0);
        chk("rst_idle", idle, 1'b1);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);
        @(negedge clk);
        compare_all();

        // Single flit: one-cycle latency, packed layout, credit consumed.
        set_in(1'b1, 4'd10, 1'b0, 32'hDEADBEEF);
        tick();
        chk("single_latency", send_flit, 1'b0);
        tick();
        chk("single_send", send_flit, 1'b1);
        chk("single_flit", flit_out, 39'h74DEADBEEF);
        chk("single_avail0", credits_avail[0], 1'b1);
        chk("single_busy", idle, 1'b0);
        chk("single_model_cred", m_cred[0], 7);
        set_cr(1'b0);
        tick();
        chk("single_idle_after_ret", idle, 1'b1);

        // Credit exhaustion on vc0.
        dut_sends = 0;
        pushed = 0;
        guard = 0;
        while (pushed < 10 && guard < 100) begin
            set_in(pushed == 9, 4'd3, 1'b0, $urandom);
            if (mq.size() < FD) pushed++;
            tick();
            guard++;
        end
        repeat (6) tick();
        chk("exh_issued_8", dut_sends, 8);
        chk("exh_avail0", credits_avail[0], 1'b0);
        chk("exh_held_2", mq.size(), 2);
        set_cr(1'b0);
        tick();
        chk("exh_ret_no_bypass", send_flit, 1'b0);
        tick();
        chk("exh_9th_issue", send_flit, 1'b1);
        drain();

        // Back-pressure: vc1 out of credits, FIFO fills to 4.
        dut_sends = 0;
        pushed = 0;
        guard = 0;
        while (pushed < 8 && guard < 100) begin
            set_in(1'b0, 4'd7, 1'b1, $urandom);
            if (mq.size() < FD) pushed++;
            tick();
            guard++;
        end
        repeat (3) tick();
        chk("bp_vc1_empty", credits_avail[1], 1'b0);
        acc2 = 0;
        for (int i = 0; i < 8; i++) begin
            if (acc2 < 5) set_in(acc2 == 4, 4'd7, 1'b1, 32'hB000 + acc2);
            if (acc2 < 5 && mq.size() < FD) acc2++;
            tick();
        end
        chk("bp_accepted_4", acc2, 4);
        chk("bp_ready_low", in_ready, 1'b0);
        guard = 0;
        while (acc2 < 5 && guard < 50) begin
            set_in(1'b1, 4'd7, 1'b1, 32'hB004);
            set_cr(1'b1);
            if (mq.size() < FD) acc2++;
            tick();
            guard++;
        end
        drain();
        chk("bp_total_sends", dut_sends, 13);

        // Issue and return on vc0 in the same cycle with counter at 1.
        pushed = 0;
        guard = 0;
        while (pushed < 7 && guard < 100) begin
            set_in(1'b0, 4'd1, 1'b0, $urandom);
            if (mq.size() < FD) pushed++;
            tick();
            guard++;
        end
        repeat (3) tick();
        chk("sim_model_cred1", m_cred[0], 1);
        set_in(1'b0, 4'd2, 1'b0, 32'hA);
        tick();
        set_in(1'b1, 4'd2, 1'b0, 32'hB);
        set_cr(1'b0);
        tick();
        chk("sim_A_sent", send_flit, 1'b1);
        chk("sim_avail_kept", credits_avail[0], 1'b1);
        tick();
        chk("sim_B_sent", send_flit, 1'b1);
        chk("sim_B_data", flit_out[31:0], 32'hB);
        chk("sim_avail0_zero", credits_avail[0], 1'b0);
        drain();

        // Overflow: return to a full vc1 counter.
        set_cr(1'b1);
        tick();
        chk("ovf_set", err_credit_ovf, 1'b1);
        chk("ovf_counter_full", idle, 1'b1);
        tick();
        chk("ovf_sticky", err_credit_ovf, 1'b1);

        // Random traffic with legal credit returns.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(9) < 6)
                set_in(1'($urandom), 4'($urandom), 1'($urandom), $urandom);
            if ($urandom_range(1) == 1) begin
                int v;
                v = int'($urandom_range(NV - 1));
                if (m_cred[v] < CI) set_cr(VB'(v));
            end
            tick();
        end
        drain();

        // Reset in the middle of a packet.
        dut_sends = 0;
        guard = 0;
        while (dut_sends < 2 && guard < 20) begin
            set_in(1'b0, 4'd5, 1'b0, 32'(guard));
            tick();
            guard++;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_send", send_flit, 1'b0);
        chk("mid_rst_flit", flit_out, 39'h0);
        chk("mid_rst_idle", idle, 1'b1);
        chk("mid_rst_ready", in_ready, 1'b0);
        chk("mid_rst_avail", credits_avail, 2'b11);
        chk("mid_rst_ovf", err_credit_ovf, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", in_ready, 1'b1);
        @(negedge clk);
        compare_all();
        dut_sends = 0;
        repeat (4) tick();
        chk("mid_no_resume", dut_sends, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_flit_injector.md
# noc_flit_injector

Credit-based flit injector between a processing element and one CONNECT network send port. It accepts flits from the PE over a valid/ready handshake and buffers them in a small FIFO. It tracks per-VC credits for the router input buffers and issues at most one flit per cycle on the network `putFlit` interface, only when the target VC holds a credit. It also consumes the network's credit returns.

## Interface
- `DATA_WIDTH`, 32, flit payload bits
- `DEST_BITS`, 4, destination port ID bits
- `NUM_VCS`, 2, virtual channels (VC_BITS = max(1, clog2(NUM_VCS)))
- `CREDIT_INIT`, 8, router buffer depth per VC; initial and maximum credits
- `FIFO_DEPTH`, 4, local flit FIFO entries (power of two, ≥2)

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  PE flit valid
- `in_ready`  out  1  injector can accept a flit
- `in_tail`  in  1  flit is the packet tail
- `in_dest`  in  DEST_BITS  destination port ID
- `in_vc`  in  VC_BITS  target VC
- `in_data`  in  DATA_WIDTH  payload
- `flit_out`  out  FLIT_W = 2+DEST_BITS+VC_BITS+DATA_WIDTH  packed {valid, tail, dest, vc, data} to `send_ports_N_putFlit_flit_in`
- `send_flit`  out  1  drives `EN_send_ports_N_putFlit`
- `credit_in`  in  CREDIT_W = 1+VC_BITS  {valid, vc} from `send_ports_N_getCredits`
- `en_recv_credit`  out  1  drives `EN_send_ports_N_getCredits`
- `credits_avail`  out  NUM_VCS  bit v = credit counter v nonzero
- `err_credit_ovf`  out  1  sticky: a credit returned to a VC already at CREDIT_INIT
- `idle`  out  1  FIFO empty and all counters at CREDIT_INIT

## Operation
- Accept: handshake when `in_valid && in_ready`. Flit pushed into the FIFO with the valid bit set.
- `in_ready` = FIFO not full. It does not depend on same-cycle pops, so a full FIFO blocks input for one cycle even if a pop occurs.
- Issue: the head flit is sent when FIFO is non-empty and `credit[head.vc] > 0`. On issue, pop the FIFO and decrement `credit[head.vc]`.
- Ordering is strict FIFO across all VCs. A blocked head stalls later flits on other VCs (accepted head-of-line blocking).
- Credit return: when `credit_in` valid bit = 1, increment `credit[credit_in.vc]`.
  - Same VC issued and returned in one cycle: counter unchanged.
  - Return to a counter already at CREDIT_INIT: counter holds, `err_credit_ovf` is set and stays set until reset.
- Counter width = clog2(CREDIT_INIT+1); unsigned; no wrap in either direction.
- `en_recv_credit` = 1 every cycle out of reset.
- Reset (including mid-packet) flushes the FIFO and sets counters to CREDIT_INIT. All outputs take their reset values: `in_ready`=0 while `rst` high, then 1; `flit_out`=0; `send_flit`=0; `en_recv_credit`=0; `credits_avail`=all ones; `err_credit_ovf`=0; `idle`=1. Partial packets are discarded and not resumed.

## Timing
- `flit_out`, `send_flit`, `credits_avail`, `err_credit_ovf`, `idle` are registered.
- Latency: flit accepted at edge N → `send_flit`=1 with that flit during cycle N+1 (earliest). No input-to-output bypass.
- `send_flit` is a one-cycle pulse per flit. `flit_out` = 0 when `send_flit`=0.
- Throughput: one flit/cycle while credits last.
- A credit sampled at edge N is usable for issue at edge N+1; no same-cycle bypass from `credit_in` to issue.
- Issue uses the pre-edge counter value. With counter = 1 and a same-cycle return on that VC, issue proceeds and the counter stays 1.

## Structure
- Package `noc_if_pkg`:
  - `DEST_BITS`, `VC_BITS`, `FLIT_W`, `CREDIT_W` derivations
  - `flit_t` / `credit_t` packed structs
  - `pack_flit` function
  - shared with PE models and monitors
- Sub-module `flit_fifo`: synchronous FIFO with registered full/empty and an asynchronous active-high reset. Credit counters, issue logic and error flag stay in `noc_flit_injector`.

## Test plan
- Single flit: push {tail=1, dest=10, vc=0, data=0xDEADBEEF} at cycle 1 → `send_flit` high cycle 2, `flit_out` = packed flit, `credits_avail[0]` stays 1, counter 7.
- Credit exhaustion: push 10 flits on vc0, no returns → exactly 8 issued, 2 held, `credits_avail[0]`=0. One credit return → 9th issues the following cycle.
- Back-pressure: no credits on vc1; push 5 flits → `in_ready` low after 4 accepted, no flit lost or duplicated after credits return.
- Simultaneous: vc0 counter at 1, issue and return same cycle → counter remains 1, next flit issues next cycle.
- Overflow: return a vc1 credit at CREDIT_INIT → `err_credit_ovf`=1 next cycle and sticky, counter stays 8.
- Reset mid-packet: assert `rst` after 2 of 4 flits sent → `send_flit` 0 immediately, `idle`=1, counters 8, FIFO empty after release.
